// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clocked-out frame, ACK check.
// Drives the shared clock/data lines open-drain through the *_oe outputs.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 1200,
  parameter int REQ_CYCLES     = 20,
  parameter int TIMEOUT_CYCLES = 150000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE
  } state_t;

  state_t      state, state_n;
  logic [1:0]  clk_sync, data_sync;
  logic        clk_prev;
  logic        sync_clk, sync_data, fall;
  logic [17:0] cnt, cnt_n;
  logic [3:0]  k, k_n;
  logic [9:0]  shreg, shreg_n;
  logic        data_oe, data_oe_n;
  logic        timeout;

  assign sync_clk  = clk_sync[1];
  assign sync_data = data_sync[1];
  assign fall      = clk_prev & ~sync_clk;
  assign timeout   = (cnt == 18'(TIMEOUT_CYCLES));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      k         <= '0;
      shreg     <= '0;
      data_oe   <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev  <= sync_clk;
      state     <= state_n;
      cnt       <= cnt_n;
      k         <= k_n;
      shreg     <= shreg_n;
      data_oe   <= data_oe_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 18'd1;
    k_n       = k;
    shreg_n   = shreg;
    data_oe_n = data_oe;
    tx_done   = 1'b0;
    tx_error  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (tx_valid) begin
          state_n = INHIBIT;
          shreg_n = {1'b1, ~^tx_data, tx_data};
          k_n     = '0;
        end
      end
      INHIBIT: begin
        if (cnt == 18'(INHIBIT_CYCLES - 1)) begin
          state_n   = REQ;
          data_oe_n = 1'b1;
        end
      end
      REQ: begin
        if (cnt == 18'(REQ_CYCLES - 1))
          state_n = SEND;
      end
      SEND: begin
        // A fall on the terminal count still wins over the timeout
        if (fall) begin
          cnt_n     = '0;
          data_oe_n = ~shreg[0];
          shreg_n   = shreg >> 1;
          k_n       = k + 4'd1;
          if (k == 4'd9)
            state_n = ACK;
        end else if (timeout) begin
          tx_error = 1'b1;
          state_n  = IDLE;
        end
      end
      ACK: begin
        if (fall) begin
          cnt_n = '0;
          if (!sync_data) begin
            state_n = WAIT_IDLE;
          end else begin
            tx_error = 1'b1;
            state_n  = IDLE;
          end
        end else if (timeout) begin
          tx_error = 1'b1;
          state_n  = IDLE;
        end
      end
      WAIT_IDLE: begin
        if (sync_clk && sync_data) begin
          tx_done = 1'b1;
          state_n = IDLE;
        end else if (fall) begin
          cnt_n = '0;
        end else if (timeout) begin
          tx_error = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n != state)
      cnt_n = '0;
    if (state_n == IDLE)
      data_oe_n = 1'b0;
  end

  assign tx_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign ps2_clk_oe  = (state == INHIBIT) || (state == REQ);
  assign ps2_data_oe = data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// with frames, pulses and phase timings checked against bench-side expectations.
module tb_ps2_host_tx;

  localparam int INH = 120;
  localparam int RQ  = 20;
  localparam int TO  = 3000;
  localparam int H   = 40;

  logic       clock = 1'b0;
  logic       resetn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_done, tx_error, busy;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (RQ),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .busy       (busy),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #50 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, rb_cnt = 0;
  int err_cyc = 0, clk_rise = 0, clk_fall = 0, dat_rise = 0;
  int acc_cyc = 0;
  logic p_clk = 1'b0, p_dat = 1'b0;

  always @(negedge clock) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (tx_done && tx_error) both_cnt <= both_cnt + 1;
    if (busy === tx_ready) rb_cnt <= rb_cnt + 1;
    if (ps2_clk_oe && !p_clk) clk_rise <= cyc;
    if (!ps2_clk_oe && p_clk) clk_fall <= cyc;
    if (ps2_data_oe && !p_dat && ps2_clk_oe) dat_rise <= cyc;
    p_clk <= ps2_clk_oe;
    p_dat <= ps2_data_oe;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Start, 8 data bits LSB first, odd parity, stop
  function automatic logic [10:0] frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = ($countones(d) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic send(input logic [7:0] d);
    @(negedge clock);
    tx_data  = d;
    tx_valid = 1'b1;
    acc_cyc  = cyc;
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  task automatic dev_xfer(input int nf, input bit ack,
                          output logic [10:0] bits, output bit got);
    int w;
    w = 0;
    bits = '0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && w < INH + RQ + 100) begin
      @(negedge clock);
      w++;
    end
    got = (ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1);
    if (!got) return;
    for (int i = 0; i < nf; i++) begin
      cycles(H / 2);
      bits[i] = ps2_data_in;
      if (i == 10) dev_data = ~ack;
      cycles(H / 2);
      dev_clk = 1'b0;
      cycles(H);
      dev_clk = 1'b1;
    end
    cycles(H);
    dev_data = 1'b1;
  endtask

  task automatic wait_result(input int base, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (done_cnt + err_cnt != base) seen = 1'b1;
    end
  endtask

  task automatic do_byte(input logic [7:0] d, input bit ack, input string tag,
                         output logic [10:0] bits);
    bit got, seen;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send(d);
    dev_xfer(11, ack, bits, got);
    chk({tag, "_req"}, 32'(got), 32'd1);
    chk({tag, "_frame"}, 32'(bits), 32'(frame(d)));
    wait_result(d0 + e0, H * 4, seen);
    cycles(2);
    chk({tag, "_end"}, 32'(seen), 32'd1);
    chk({tag, "_done"}, 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
    chk({tag, "_err"}, 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
    chk({tag, "_ready"}, 32'(tx_ready), 32'd1);
  endtask

  initial begin
    logic [10:0] bits;
    bit got, seen;
    int d0, e0;
    resetn   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    cycles(3);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("rst_pulses", 32'({tx_done, tx_error}), 32'd0);
    resetn = 1'b1;
    cycles(3);

    do_byte(8'hED, 1'b1, "ed", bits);
    chk("ed_parity", 32'(bits[9]), 32'd1);
    chk("ed_accept_lat", 32'(clk_rise - acc_cyc), 32'd1);
    chk("ed_clk_oe_len", 32'(clk_fall - clk_rise), 32'(INH + RQ));
    chk("ed_data_lag", 32'(dat_rise - clk_rise), 32'(INH));

    do_byte(8'h01, 1'b1, "b01", bits);
    chk("b01_parity", 32'(bits[9]), 32'd0);
    do_byte(8'h00, 1'b1, "b00", bits);
    chk("b00_parity", 32'(bits[9]), 32'd1);

    for (int n = 0; n < 4; n++)
      do_byte(8'($urandom_range(0, 255)), 1'b1, "rnd", bits);

    // Device never answers the request
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'($urandom_range(0, 255)));
    wait_result(d0 + e0, INH + RQ + TO + 100, seen);
    cycles(2);
    chk("to_seen", 32'(seen), 32'd1);
    chk("to_err", 32'(err_cnt - e0), 32'd1);
    chk("to_done", 32'(done_cnt - d0), 32'd0);
    chk("to_time", 32'(err_cyc - clk_fall), 32'(TO));
    chk("to_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    chk("to_ready", 32'(tx_ready), 32'd1);

    do_byte(8'($urandom_range(0, 255)), 1'b0, "nack", bits);

    // Reset in the middle of the data bits
    send(8'h00);
    dev_xfer(4, 1'b1, bits, got);
    chk("mid_req", 32'(got), 32'd1);
    chk("mid_data_oe", 32'(ps2_data_oe), 32'd1);
    #20;
    resetn = 1'b0;
    #1;
    chk("mid_rst_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    chk("mid_rst_ready", 32'(tx_ready), 32'd1);
    @(negedge clock);
    resetn = 1'b1;
    cycles(3);

    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hFF);
    cycles(5);
    tx_data  = 8'h12;
    tx_valid = 1'b1;
    cycles(3);
    tx_valid = 1'b0;
    dev_xfer(11, 1'b1, bits, got);
    chk("ff_req", 32'(got), 32'd1);
    chk("ff_frame", 32'(bits), 32'(frame(8'hFF)));
    wait_result(d0 + e0, H * 4, seen);
    cycles(2);
    chk("ff_done", 32'(done_cnt - d0), 32'd1);
    chk("ff_err", 32'(err_cnt - e0), 32'd0);
    cycles(INH + 50);
    chk("ff_no_queue", 32'(busy), 32'd0);

    chk("never_both", 32'(both_cnt), 32'd0);
    chk("busy_is_not_ready", 32'(rb_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
